// File: rtl/pmod_keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// pmod_keypad_scanner_if
//   Key-event bundle between the keypad scanner and its consumer (the
//   downstream one-hot state register).
//
//   Handshake: valid-only stream. key_valid is a single-cycle strobe that
//   qualifies key_code in that cycle. There is no ready/back-pressure, so the
//   consumer must take every strobe. key_code holds its value between strobes.
//   key_pressed and fsm_state are level signals that are meaningful on every
//   cycle.
//
//   Signals:
//     key_code    [3:0] hex value of the last accepted key
//     key_valid         one-cycle strobe for a new (or repeated) key
//     key_pressed       high while a key is held, including the release debounce
//     fsm_state   [2:0] one-hot scanner state (001 scan, 010 press debounce, 100 held)
//
//   Modports: master = scanner (drives), slave = consumer (observes).
// ---------------------------------------------------------------------------
interface pmod_keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;
  logic [2:0] fsm_state;

  modport master (output key_code, key_valid, key_pressed, fsm_state);
  modport slave  (input  key_code, key_valid, key_pressed, fsm_state);
endinterface

// File: rtl/pmod_keypad_scanner.sv
// ---------------------------------------------------------------------------
// pmod_keypad_scanner
//   Scans a Pmod KYPD 4x4 keypad: drives one column low at a time, samples the
//   synchronised rows, debounces press and release, and emits a hex key code
//   with a one-cycle valid strobe. The one-hot FSM state is exported.
//
//   Ports:
//     clk     system clock, rising edge
//     rst     asynchronous reset, active low
//     enable  low: all state and counters hold, key_valid forced 0
//     row_n   [3:0] keypad rows, active low, asynchronous to clk
//     col_n   [3:0] column drive, active low, exactly one bit low
//     key     pmod_keypad_scanner_if.master (key_code, key_valid,
//             key_pressed, fsm_state)
//
//   Parameters:
//     CLK_DIV        cycles each column is driven before rows are sampled (>=4)
//     DEBOUNCE_CNT   consecutive stable cycles to accept press/release (>=2)
//     REPEAT_CYCLES  auto-repeat interval while held (KEYPAD_REPEAT_EN only)
//
//   Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of key_valid while
//   a key is held). Undefined by default: one key_valid per accepted press.
// ---------------------------------------------------------------------------
module pmod_keypad_scanner #(
  parameter int CLK_DIV       = 1000,
  parameter int DEBOUNCE_CNT  = 20000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [3:0]                   row_n,
  output logic [3:0]                   col_n,
  pmod_keypad_scanner_if.master        key
);

  if (CLK_DIV < 4)       begin : g_bad_clk_div  $error("CLK_DIV must be >= 4");       end
  if (DEBOUNCE_CNT < 2)  begin : g_bad_debounce $error("DEBOUNCE_CNT must be >= 2");  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat   $error("REPEAT_CYCLES must be >= 2"); end

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  typedef enum logic [2:0] {
    SCAN      = 3'b001,
    DEB_PRESS = 3'b010,
    HELD      = 3'b100
  } state_t;

  state_t        state_q, state_d;
  logic          releasing_q, releasing_d;  // release-debounce sub-phase of HELD
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] deb_q, deb_d;              // press and release share this counter
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic [3:0]    sync1_q, row_s;
  logic          one_low;
  logic [1:0]    row_hit;
  logic [3:0]    lat_pattern;
  logic [2:0]    state_out;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  // Only a single low row is a usable press; several low rows on one column
  // can be a ghost from a multi-key press and are ignored.
  always_comb begin
    one_low = 1'b1;
    row_hit = 2'd0;
    case (row_s)
      4'b1110: row_hit = 2'd0;
      4'b1101: row_hit = 2'd1;
      4'b1011: row_hit = 2'd2;
      4'b0111: row_hit = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign lat_pattern = ~(4'b0001 << row_idx_q);

  always_comb begin
    state_d     = state_q;
    releasing_d = releasing_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    row_idx_d   = row_idx_q;
    code_d      = code_q;
    valid_d     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    case (state_q)
      SCAN: begin
        releasing_d = 1'b0;
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low) begin
            row_idx_d = row_hit;
            deb_d     = '0;
            state_d   = DEB_PRESS;   // column stays frozen
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEB_PRESS: begin
        if (row_s != lat_pattern) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = HELD;
          code_d  = key_map(row_idx_q, col_q);
          valid_d = 1'b1;
          deb_d   = '0;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          deb_d = deb_q + BW'(1);
        end
      end
      HELD: begin
        if (row_s != 4'hF) begin
          deb_d       = '0;
          releasing_d = 1'b0;
        end else if (deb_q == DEB_LAST) begin
          state_d     = SCAN;
          col_d       = col_q + 2'd1;
          dwell_d     = '0;
          deb_d       = '0;
          releasing_d = 1'b0;
        end else begin
          deb_d       = deb_q + BW'(1);
          releasing_d = 1'b1;
        end
`ifdef KEYPAD_REPEAT_EN
        // Any deviation from the held pattern (bounce or release) restarts
        // the repeat interval.
        if (row_s != lat_pattern) begin
          rep_d = '0;
        end else if (rep_q == REP_LAST) begin
          rep_d   = '0;
          valid_d = 1'b1;
        end else begin
          rep_d = rep_q + RW'(1);
        end
`endif
      end
      default: begin
        state_d     = SCAN;
        col_d       = 2'd0;
        dwell_d     = '0;
        deb_d       = '0;
        releasing_d = 1'b0;
      end
    endcase
  end

  // The synchroniser keeps sampling while disabled so row_s is fresh on
  // re-enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 4'hF;
      row_s   <= 4'hF;
    end else begin
      sync1_q <= row_n;
      row_s   <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state_q <= SCAN;
    else if (enable) state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      releasing_q <= 1'b0;
      col_q       <= 2'd0;
      dwell_q     <= '0;
      deb_q       <= '0;
      row_idx_q   <= 2'd0;
      code_q      <= 4'h0;
      valid_q     <= 1'b0;
    end else if (enable) begin
      releasing_q <= releasing_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      row_idx_q   <= row_idx_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
    end else begin
      valid_q     <= 1'b0;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rep_q <= '0;
    else if (enable) rep_q <= rep_d;
  end
`endif

  // An illegal state register value is reported as SCAN and is steered back
  // to SCAN on the next enabled edge.
  always_comb begin
    case (state_q)
      SCAN, DEB_PRESS, HELD: state_out = state_q;
      default:               state_out = SCAN;
    endcase
  end

  assign col_n           = ~(4'b0001 << col_q);
  assign key.key_code    = code_q;
  assign key.key_valid   = valid_q & enable;
  assign key.key_pressed = (state_q == HELD);
  assign key.fsm_state   = state_out;

endmodule
